// File: rtl/sequence_checker.sv
// Sequence checker: locks onto a stream that advances by STEP per valid sample,
// flags mismatches while locked. Optional error counter: define SEQ_CHECK_ERRCNT_EN.
module sequence_checker #(
   parameter int STEP     = 1,
   parameter int LOCK_CNT = 4,
   parameter int LOSS_CNT = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [7:0]  data,
   output logic        locked,
   output logic        error,
   output logic [7:0]  expected,
   output logic [15:0] err_count
);

   localparam logic [7:0] STEP_C = 8'(STEP);
   localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);
   localparam logic [3:0] LOSS_C = 4'(LOSS_CNT);

   typedef enum logic {HUNT, LOCKED} state_t;

   state_t      state_q;
   logic [3:0]  run_q, bad_q;
   logic [7:0]  expected_q;
   logic        locked_q, error_q;
   logic        match;
   logic [3:0]  run_d, bad_d;

   always_comb begin
      match = (data == expected_q);
      run_d = ((run_q == 4'd0) || !match) ? 4'd1 : run_q + 4'd1;
      bad_d = bad_q + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= HUNT;
         run_q      <= 4'd0;
         bad_q      <= 4'd0;
         expected_q <= 8'h00;
         locked_q   <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         error_q <= 1'b0;
         if (enable) begin
            case (state_q)
               HUNT: begin
                  run_q      <= run_d;
                  expected_q <= data + STEP_C;
                  if (run_d == LOCK_C) begin
                     state_q  <= LOCKED;
                     locked_q <= 1'b1;
                     bad_q    <= 4'd0;
                  end
               end
               LOCKED: begin
                  if (match) begin
                     bad_q      <= 4'd0;
                     expected_q <= data + STEP_C;
                  end else begin
                     // Flywheel: keep predicting from our own count, not the bad sample
                     error_q    <= 1'b1;
                     expected_q <= expected_q + STEP_C;
                     if (bad_d == LOSS_C) begin
                        state_q  <= HUNT;
                        locked_q <= 1'b0;
                        run_q    <= 4'd0;
                        bad_q    <= 4'd0;
                     end else begin
                        bad_q <= bad_d;
                     end
                  end
               end
               default: begin
                  state_q  <= HUNT;
                  locked_q <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef SEQ_CHECK_ERRCNT_EN
   logic [15:0] err_cnt_q;

   // Saturates rather than wraps so a long-running fault never reads as healthy
   always_ff @(posedge clk) begin
      if (reset) begin
         err_cnt_q <= 16'd0;
      end else if (enable && (state_q == LOCKED) && !match && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_q <= err_cnt_q + 16'd1;
      end
   end

   assign err_count = err_cnt_q;
`else
   assign err_count = 16'd0;
`endif

   assign locked   = locked_q;
   assign error    = error_q;
   assign expected = expected_q;

endmodule

// File: tb/tb_sequence_checker.sv
// Scoreboard bench for sequence_checker: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares each registered output.
module tb_sequence_checker;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [7:0]  data = 8'h00;
   logic        locked, error;
   logic [7:0]  expected;
   logic [15:0] err_count;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic        l;
      logic        e;
      logic [7:0]  x;
      logic [15:0] c;
   } exp_t;

   exp_t sb[$];

   sequence_checker #(.STEP(1), .LOCK_CNT(4), .LOSS_CNT(3)) dut (
      .clk(clk), .reset(reset), .enable(enable), .data(data),
      .locked(locked), .error(error), .expected(expected), .err_count(err_count)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] ec(input int n);
`ifdef SEQ_CHECK_ERRCNT_EN
      return 16'(n);
`else
      return 16'd0;
`endif
   endfunction

   // Drive one cycle of inputs and push the outputs expected after that edge
   task automatic step(input logic r, input logic en, input logic [7:0] d,
                       input logic l, input logic e, input logic [7:0] x, input int c);
      exp_t t;
      reset  = r;
      enable = en;
      data   = d;
      @(posedge clk);
      t.l = l; t.e = e; t.x = x; t.c = ec(c);
      sb.push_back(t);
      #1;
   endtask

   initial begin : monitor
      exp_t t;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            t = sb.pop_front();
            checks++;
            if (locked !== t.l) begin
               failures++;
               $display("FAIL locked: got %b want %b (check %0d)", locked, t.l, checks);
            end
            checks++;
            if (error !== t.e) begin
               failures++;
               $display("FAIL error: got %b want %b (check %0d)", error, t.e, checks);
            end
            checks++;
            if (expected !== t.x) begin
               failures++;
               $display("FAIL expected: got %h want %h (check %0d)", expected, t.x, checks);
            end
            checks++;
            if (err_count !== t.c) begin
               failures++;
               $display("FAIL err_count: got %0d want %0d (check %0d)", err_count, t.c, checks);
            end
         end
      end
   end

   initial begin : stim
      // Reset held two cycles with a live sample present
      step(1, 1, 8'h55, 0, 0, 8'h00, 0);
      step(1, 1, 8'h55, 0, 0, 8'h00, 0);

      // Basic lock on 0x10..0x13
      step(0, 1, 8'h10, 0, 0, 8'h11, 0);
      step(0, 1, 8'h11, 0, 0, 8'h12, 0);
      step(0, 1, 8'h12, 0, 0, 8'h13, 0);
      step(0, 1, 8'h13, 1, 0, 8'h14, 0);
      for (int d = 8'h14; d <= 8'h1F; d++)
         step(0, 1, 8'(d), 1, 0, 8'(d + 1), 0);

      // Single mismatch while locked, then recovery
      step(0, 1, 8'h99, 1, 1, 8'h21, 1);
      step(0, 1, 8'h21, 1, 0, 8'h22, 1);

      // Loss of lock after three mismatches, then relock from a fresh run
      step(1, 1, 8'h00, 0, 0, 8'h00, 0);
      step(0, 1, 8'h40, 0, 0, 8'h41, 0);
      step(0, 1, 8'h41, 0, 0, 8'h42, 0);
      step(0, 1, 8'h42, 0, 0, 8'h43, 0);
      step(0, 1, 8'h43, 1, 0, 8'h44, 0);
      step(0, 1, 8'h00, 1, 1, 8'h45, 1);
      step(0, 1, 8'h00, 1, 1, 8'h46, 2);
      step(0, 1, 8'h00, 0, 1, 8'h47, 3);
      step(0, 1, 8'h47, 0, 0, 8'h48, 3);
      step(0, 1, 8'h48, 0, 0, 8'h49, 3);
      step(0, 1, 8'h49, 0, 0, 8'h4A, 3);
      step(0, 1, 8'h4A, 1, 0, 8'h4B, 3);

      // Reset mid-lock wins over a matching sample
      step(1, 1, 8'h4B, 0, 0, 8'h00, 0);

      // Wrap through 0xFF
      step(0, 1, 8'hFC, 0, 0, 8'hFD, 0);
      step(0, 1, 8'hFD, 0, 0, 8'hFE, 0);
      step(0, 1, 8'hFE, 0, 0, 8'hFF, 0);
      step(0, 1, 8'hFF, 1, 0, 8'h00, 0);
      step(0, 1, 8'h00, 1, 0, 8'h01, 0);
      step(0, 1, 8'h01, 1, 0, 8'h02, 0);

      // Hunt mismatch restarts the run
      step(1, 1, 8'h00, 0, 0, 8'h00, 0);
      step(0, 1, 8'h10, 0, 0, 8'h11, 0);
      step(0, 1, 8'h11, 0, 0, 8'h12, 0);
      step(0, 1, 8'h20, 0, 0, 8'h21, 0);
      step(0, 1, 8'h21, 0, 0, 8'h22, 0);
      step(0, 1, 8'h22, 0, 0, 8'h23, 0);
      step(0, 1, 8'h23, 1, 0, 8'h24, 0);

      // Enable gaps freeze state; error clears on an idle cycle
      step(1, 1, 8'h00, 0, 0, 8'h00, 0);
      step(0, 1, 8'h30, 0, 0, 8'h31, 0);
      step(0, 0, 8'h99, 0, 0, 8'h31, 0);
      step(0, 1, 8'h31, 0, 0, 8'h32, 0);
      step(0, 0, 8'h99, 0, 0, 8'h32, 0);
      step(0, 1, 8'h32, 0, 0, 8'h33, 0);
      step(0, 0, 8'h99, 0, 0, 8'h33, 0);
      step(0, 1, 8'h33, 1, 0, 8'h34, 0);
      step(0, 0, 8'h00, 1, 0, 8'h34, 0);
      step(0, 1, 8'h77, 1, 1, 8'h35, 1);
      step(0, 0, 8'h77, 1, 0, 8'h35, 1);

      enable = 1'b0;
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain: %0d expectations left, want 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
